// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
package modexp_pkg;

    localparam int MSIZE_W = 12;
    localparam logic ONE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TO_X,
        ST_TO_ONE,
        ST_SQR,
        ST_MUL,
        ST_FROM,
        ST_DONE
    } state_e;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_e;

    function automatic logic is_op_state(state_e s);
        return (s == ST_TO_X) || (s == ST_TO_ONE) || (s == ST_SQR) ||
               (s == ST_MUL) || (s == ST_FROM);
    endfunction

endpackage

// File: rtl/modexp_op_mux.sv
// Selects the multiplier operand pair for the current operation state.
module modexp_op_mux
    import modexp_pkg::*;
#(
    parameter int NBITS = 256
) (
    input  state_e             state_i,
    input  logic [NBITS-1:0]   acc_i,
    input  logic [NBITS-1:0]   xm_i,
    input  logic [NBITS-1:0]   base_i,
    input  logic [NBITS-1:0]   r2_i,
    output logic [NBITS-1:0]   a_o,
    output logic [NBITS-1:0]   b_o
);

    always_comb begin
        a_o = '0;
        b_o = '0;
        case (state_i)
            ST_TO_X:   begin a_o = base_i;          b_o = r2_i;            end
            ST_TO_ONE: begin a_o = NBITS'(ONE);     b_o = r2_i;            end
            ST_SQR:    begin a_o = acc_i;           b_o = acc_i;           end
            ST_MUL:    begin a_o = acc_i;           b_o = xm_i;            end
            ST_FROM:   begin a_o = acc_i;           b_o = NBITS'(ONE);     end
            default:   begin a_o = '0;              b_o = '0;              end
        endcase
    end

endmodule

// File: rtl/modexp_sequencer.sv
// Drives a shared Montgomery multiplier through a left-to-right
// square-and-multiply exponentiation, with a per-multiply watchdog.
module modexp_sequencer
    import modexp_pkg::*;
#(
    parameter int NBITS  = 256,
    parameter int EBITS  = 256,
    parameter int WDOG_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_p,
    input  logic [NBITS-1:0]    base,
    input  logic [EBITS-1:0]    exp,
    input  logic [MSIZE_W-1:0]  exp_size,
    input  logic [NBITS-1:0]    m,
    input  logic [MSIZE_W-1:0]  m_size,
    input  logic [NBITS-1:0]    r2_mod_m,
    output logic                mul_enable_p,
    output logic [NBITS-1:0]    mul_a,
    output logic [NBITS-1:0]    mul_b,
    output logic [NBITS-1:0]    mul_m,
    output logic [MSIZE_W-1:0]  mul_m_size,
    input  logic [NBITS-1:0]    mul_y,
    input  logic                mul_done_p,
    output logic [NBITS-1:0]    y,
    output logic                busy,
    output logic                done_irq_p,
    output logic                err_p,
    output state_e              dbg_state_o
);

    localparam int IDX_W = $clog2(EBITS + 1);

    state_e              state_q, state_d;
    phase_e              phase_q, phase_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [NBITS-1:0]    acc_q, acc_d;
    logic [NBITS-1:0]    xm_q, xm_d;
    logic [NBITS-1:0]    y_q, y_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [NBITS-1:0]    base_q, r2_q, m_q;
    logic [EBITS-1:0]    exp_q;
    logic [MSIZE_W-1:0]  msize_q;

    logic                accept;
    logic [MSIZE_W-1:0]  es_clamp;
    logic [EBITS-1:0]    exp_sh;
    logic                cur_bit;

    // A start arriving alongside the completion pulse must not launch a job.
    assign accept   = (state_q == ST_IDLE) && start_p && !done_q;
    assign es_clamp = (exp_size > MSIZE_W'(EBITS)) ? MSIZE_W'(EBITS) : exp_size;
    assign exp_sh   = exp_q >> (idx_q - IDX_W'(1));
    assign cur_bit  = exp_sh[0];

    modexp_op_mux #(.NBITS(NBITS)) u_op_mux (
        .state_i (state_q),
        .acc_i   (acc_q),
        .xm_i    (xm_q),
        .base_i  (base_q),
        .r2_i    (r2_q),
        .a_o     (mul_a),
        .b_o     (mul_b)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        acc_d   = acc_q;
        xm_d    = xm_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_TO_X;
                    phase_d = PH_ISSUE;
                    busy_d  = 1'b1;
                    idx_d   = es_clamp[IDX_W-1:0];
                end
            end
            ST_DONE: begin
                y_d     = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                if (phase_q == PH_ISSUE) begin
                    wdog_d  = '0;
                    phase_d = PH_WAIT;
                end else if (mul_done_p) begin
                    phase_d = PH_ISSUE;
                    if (state_q == ST_TO_X) xm_d = mul_y;
                    else                    acc_d = mul_y;
                    case (state_q)
                        ST_TO_X:   state_d = ST_TO_ONE;
                        ST_TO_ONE: state_d = (idx_q == '0) ? ST_FROM : ST_SQR;
                        ST_SQR: begin
                            if (cur_bit) begin
                                state_d = ST_MUL;
                            end else begin
                                idx_d   = idx_q - IDX_W'(1);
                                state_d = (idx_q == IDX_W'(1)) ? ST_FROM : ST_SQR;
                            end
                        end
                        ST_MUL: begin
                            idx_d   = idx_q - IDX_W'(1);
                            state_d = (idx_q == IDX_W'(1)) ? ST_FROM : ST_SQR;
                        end
                        default:   state_d = ST_DONE;
                    endcase
                end else if (wdog_q == '1) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    phase_d = PH_ISSUE;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= PH_ISSUE;
            idx_q   <= '0;
            wdog_q  <= '0;
            acc_q   <= '0;
            xm_q    <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            base_q  <= '0;
            exp_q   <= '0;
            r2_q    <= '0;
            m_q     <= '0;
            msize_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            acc_q   <= acc_d;
            xm_q    <= xm_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                base_q  <= base;
                exp_q   <= exp;
                r2_q    <= r2_mod_m;
                m_q     <= m;
                msize_q <= m_size;
            end
        end
    end

    assign mul_enable_p = is_op_state(state_q) && (phase_q == PH_ISSUE);
    assign mul_m        = m_q;
    assign mul_m_size   = msize_q;
    assign y            = y_q;
    assign busy         = busy_q;
    assign done_irq_p   = done_q;
    assign err_p        = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Directed bench: behavioural Montgomery multiplier plus hand-computed results.
module tb_modexp_sequencer;
    import modexp_pkg::*;

    localparam int NBITS  = 16;
    localparam int EBITS  = 16;
    localparam int WDOG_W = 8;
    localparam int LAT    = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_p;
    logic [NBITS-1:0]   base;
    logic [EBITS-1:0]   exp;
    logic [MSIZE_W-1:0] exp_size;
    logic [NBITS-1:0]   m;
    logic [MSIZE_W-1:0] m_size;
    logic [NBITS-1:0]   r2_mod_m;
    logic               mul_enable_p;
    logic [NBITS-1:0]   mul_a, mul_b, mul_m;
    logic [MSIZE_W-1:0] mul_m_size;
    logic [NBITS-1:0]   mul_y;
    logic               mul_done_p;
    logic [NBITS-1:0]   y;
    logic               busy, done_irq_p, err_p;
    state_e             dbg_state;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cnt = 0;
    bit hang = 0;
    logic [NBITS-1:0] a_l, b_l;

    modexp_sequencer #(.NBITS(NBITS), .EBITS(EBITS), .WDOG_W(WDOG_W)) dut (
        .clk(clk), .rst(rst), .start_p(start_p), .base(base), .exp(exp),
        .exp_size(exp_size), .m(m), .m_size(m_size), .r2_mod_m(r2_mod_m),
        .mul_enable_p(mul_enable_p), .mul_a(mul_a), .mul_b(mul_b),
        .mul_m(mul_m), .mul_m_size(mul_m_size), .mul_y(mul_y),
        .mul_done_p(mul_done_p), .y(y), .busy(busy),
        .done_irq_p(done_irq_p), .err_p(err_p), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // a*b*2^-m_size mod m by bitwise Montgomery reduction
    function automatic logic [NBITS-1:0] mont(input logic [NBITS-1:0] a,
                                              input logic [NBITS-1:0] b);
        logic [63:0] t;
        t = 64'(a) * 64'(b);
        for (int i = 0; i < int'(m_size); i++) begin
            if (t[0]) t = t + 64'(m);
            t = t >> 1;
        end
        if (t >= 64'(m)) t = t - 64'(m);
        return t[NBITS-1:0];
    endfunction

    always @(negedge clk) begin
        mul_done_p = 1'b0;
        if (mul_enable_p) pulses++;
        if (done_irq_p) done_cnt++;
        if (err_p) err_cnt++;
        if (rst) begin
            cnt = 0;
        end else if (cnt != 0) begin
            cnt--;
            if (cnt == 0 && !hang) begin
                mul_y = mont(a_l, b_l);
                mul_done_p = 1'b1;
            end
        end else if (mul_enable_p) begin
            a_l = mul_a;
            b_l = mul_b;
            cnt = LAT;
        end
    end

    task automatic pulse_start(input logic [NBITS-1:0] b_in, input logic [EBITS-1:0] e_in,
                               input logic [MSIZE_W-1:0] es_in);
        @(negedge clk);
        base = b_in; exp = e_in; exp_size = es_in;
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
    endtask

    task automatic wait_done(input string name, output bit seen);
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (done_irq_p) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout got no done_irq_p required done within 2000 cycles", name);
        end
    endtask

    task automatic check_job(input string name, input logic [NBITS-1:0] b_in,
                             input logic [EBITS-1:0] e_in, input logic [MSIZE_W-1:0] es_in,
                             input logic [NBITS-1:0] y_exp, input int p_exp);
        bit seen;
        int d0;
        pulses = 0;
        d0 = done_cnt;
        pulse_start(b_in, e_in, es_in);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s_busy got %0b required 1", name, busy);
        end
        wait_done(name, seen);
        checks++;
        if (y !== y_exp) begin
            errors++; $display("FAIL %s_y got %0d required %0d", name, y, y_exp);
        end
        checks++;
        if (pulses != p_exp) begin
            errors++; $display("FAIL %s_pulses got %0d required %0d", name, pulses, p_exp);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL %s_end got busy=%0b dones=%0d required busy=0 dones=%0d",
                     name, busy, done_cnt - d0, 1);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (y !== 0 || busy !== 0 || done_irq_p !== 0 || err_p !== 0 || mul_enable_p !== 0 ||
            mul_a !== 0 || mul_b !== 0 || mul_m !== 0 || mul_m_size !== 0) begin
            errors++;
            $display("FAIL reset_outputs got y=%0d busy=%0b en=%0b a=%0d m=%0d required all 0",
                     y, busy, mul_enable_p, mul_a, mul_m);
        end
    endtask

    task automatic test_basic();
        check_job("basic", 16'd4, 16'd13, 12'd4, 16'd445, 10);
        checks++;
        if (mul_m !== 16'd497 || mul_m_size !== 12'd9) begin
            errors++;
            $display("FAIL basic_latched got m=%0d msize=%0d required 497 9", mul_m, mul_m_size);
        end
    endtask

    task automatic test_scan_edges();
        check_job("exp_zero", 16'd4, 16'd0, 12'd4, 16'd1, 7);
        check_job("size_zero", 16'd4, 16'd13, 12'd0, 16'd1, 3);
        check_job("exp_one", 16'd4, 16'd1, 12'd1, 16'd4, 5);
        // exp_size beyond EBITS scans all 16 bits: 3 + 16 + popcount(13)
        check_job("clamp", 16'd4, 16'd13, 12'd4095, 16'd445, 22);
    endtask

    task automatic test_restart_ignored();
        bit seen;
        pulses = 0;
        pulse_start(16'd4, 16'd13, 12'd4);
        repeat (12) @(negedge clk);
        base = 16'd7; exp = 16'd3;
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        wait_done("restart", seen);
        checks++;
        if (y !== 16'd445) begin
            errors++; $display("FAIL restart_y got %0d required 445", y);
        end
        checks++;
        if (pulses != 10) begin
            errors++; $display("FAIL restart_pulses got %0d required 10", pulses);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        pulse_start(16'd4, 16'd1, 12'd1);
        wait_done("b2b", seen);
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        checks++;
        if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL b2b_ignored got busy=%0b state=%0d required busy=0 idle", busy, dbg_state);
        end
        check_job("b2b_next", 16'd4, 16'd13, 12'd4, 16'd445, 10);
    endtask

    task automatic test_reset_mid();
        int d0;
        bit found = 0;
        d0 = done_cnt;
        pulse_start(16'd4, 16'd13, 12'd4);
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (dbg_state == ST_SQR && !mul_enable_p) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rstmid_reach got state=%0d required SQR wait", dbg_state);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (y !== 0 || busy !== 0 || mul_enable_p !== 0 || mul_a !== 0 || mul_b !== 0 ||
            mul_m !== 0 || done_irq_p !== 0 || err_p !== 0) begin
            errors++;
            $display("FAIL rstmid_outputs got y=%0d busy=%0b a=%0d m=%0d required all 0",
                     y, busy, mul_a, mul_m);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin
            errors++; $display("FAIL rstmid_nodone got %0d required %0d", done_cnt, d0);
        end
        check_job("rstmid_after", 16'd4, 16'd13, 12'd4, 16'd445, 10);
    endtask

    task automatic test_watchdog();
        int d0, e0, t;
        bit seen = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        hang = 1;
        pulses = 0;
        pulse_start(16'd9, 16'd13, 12'd4);
        t = 1;
        for (int i = 0; i < 1000 && !seen; i++) begin
            if (err_p) seen = 1;
            else begin @(negedge clk); t++; end
        end
        hang = 0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL wdog_timeout got no err_p required err within 1000 cycles");
        end
        // enable to err_p: 256 WAIT cycles at most plus registering
        checks++;
        if (t < 255 || t > 258) begin
            errors++; $display("FAIL wdog_latency got %0d required 255..258", t);
        end
        checks++;
        if (busy !== 0 || y !== 16'd445 || done_cnt != d0 || pulses != 1) begin
            errors++;
            $display("FAIL wdog_state got busy=%0b y=%0d dones=%0d pulses=%0d required 0 445 %0d 1",
                     busy, y, done_cnt, pulses, d0);
        end
        @(negedge clk);
        checks++;
        if (err_cnt != e0 + 1 || err_p !== 0) begin
            errors++; $display("FAIL wdog_pulse got count=%0d required 1", err_cnt - e0);
        end
        repeat (8) @(negedge clk);
        check_job("wdog_after", 16'd4, 16'd13, 12'd4, 16'd445, 10);
    endtask

    initial begin
        rst = 1'b1; start_p = 1'b0;
        base = '0; exp = '0; exp_size = '0;
        m = 16'd497; m_size = 12'd9; r2_mod_m = 16'd225;
        mul_y = '0; mul_done_p = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_scan_edges();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
